// File: rtl/button_menu_ctrl_pkg.sv
// Shared types and helpers for the button-driven parameter menu.
package button_menu_pkg;

  typedef enum logic {
    VIEW = 1'b0,
    EDIT = 1'b1
  } menu_state_e;

  function automatic longint timeout_cycles(input longint timeout_ns, input longint period_ns);
    return timeout_ns / period_ns;
  endfunction

  // Counter only needs to reach cycles-1, so clog2(cycles) bits are enough.
  function automatic int timeout_cnt_width(input longint timeout_ns, input longint period_ns);
    longint c;
    c = timeout_cycles(timeout_ns, period_ns);
    return (c <= 2) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/button_menu_ctrl_if.sv
// Button pulses in, committed parameters and edit status out.
interface button_menu_if #(
  parameter int NUMBER_PARAMS = 3,
  parameter int VALUE_WIDTH   = 8
);
  localparam int IW = $clog2(NUMBER_PARAMS);

  logic                                 mode_i;
  logic                                 plus_i;
  logic                                 minus_i;
  logic                                 button_4_i;
  logic [NUMBER_PARAMS*VALUE_WIDTH-1:0] params_o;
  logic                                 edit_active_o;
  logic [IW-1:0]                        edit_index_o;
  logic [VALUE_WIDTH-1:0]               edit_value_o;
  logic                                 commit_o;
  logic                                 timeout_o;

  modport master (
    output mode_i, plus_i, minus_i, button_4_i,
    input  params_o, edit_active_o, edit_index_o, edit_value_o, commit_o, timeout_o
  );

  modport slave (
    input  mode_i, plus_i, minus_i, button_4_i,
    output params_o, edit_active_o, edit_index_o, edit_value_o, commit_o, timeout_o
  );
endinterface

// File: rtl/button_menu_ctrl_sat_updown.sv
// Registered saturating up/down counter with synchronous load; holds the shadow value.
module sat_updown #(
  parameter int VALUE_WIDTH = 8,
  parameter int VALUE_MIN   = 0,
  parameter int VALUE_MAX   = 200
) (
  input  logic                   clk_i,
  input  logic                   nReset_i,
  input  logic                   load_i,
  input  logic [VALUE_WIDTH-1:0] load_value_i,
  input  logic                   up_i,
  input  logic                   down_i,
  output logic [VALUE_WIDTH-1:0] value_o
);
  typedef logic [VALUE_WIDTH:0] wide_t;
  localparam wide_t MAX_W = wide_t'(VALUE_MAX);
  localparam wide_t MIN_W = wide_t'(VALUE_MIN);

  logic [VALUE_WIDTH-1:0] value_q, value_d;

  function automatic logic [VALUE_WIDTH-1:0] sat_inc(input logic [VALUE_WIDTH-1:0] v);
    wide_t s;
    s = {1'b0, v} + wide_t'(1);
    if (s > MAX_W) s = MAX_W;
    return s[VALUE_WIDTH-1:0];
  endfunction

  // The extra top bit flags an underflow past zero.
  function automatic logic [VALUE_WIDTH-1:0] sat_dec(input logic [VALUE_WIDTH-1:0] v);
    wide_t d;
    d = {1'b0, v} - wide_t'(1);
    if (d[VALUE_WIDTH] || d < MIN_W) d = MIN_W;
    return d[VALUE_WIDTH-1:0];
  endfunction

  always_comb begin
    value_d = value_q;
    if (load_i)                 value_d = load_value_i;
    else if (up_i && !down_i)   value_d = sat_inc(value_q);
    else if (down_i && !up_i)   value_d = sat_dec(value_q);
  end

  always_ff @(posedge clk_i) begin
    if (!nReset_i) value_q <= '0;
    else           value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/button_menu_ctrl.sv
// Menu FSM and committed-parameter register file; shadow value lives in sat_updown.
module button_menu_ctrl
  import button_menu_pkg::*;
#(
  parameter int     NUMBER_PARAMS   = 3,
  parameter int     VALUE_WIDTH     = 8,
  parameter int     VALUE_MIN       = 0,
  parameter int     VALUE_MAX       = 200,
  parameter int     RESET_VALUE     = 100,
  parameter longint CLOCK_PERIOD_NS = 20,
  parameter longint EDIT_TIMEOUT_NS = 64'd5_000_000_000
) (
  input  logic             clk_i,
  input  logic             nReset_i,
  button_menu_if.slave     bus
);
  localparam int     IW             = $clog2(NUMBER_PARAMS);
  localparam longint TIMEOUT_CYCLES = timeout_cycles(EDIT_TIMEOUT_NS, CLOCK_PERIOD_NS);
  localparam int     CW             = timeout_cnt_width(EDIT_TIMEOUT_NS, CLOCK_PERIOD_NS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUMBER_PARAMS - 1);

  menu_state_e            state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   commit_q, commit_d;
  logic                   timeout_q, timeout_d;
  logic [VALUE_WIDTH-1:0] params_q [NUMBER_PARAMS];
  logic [VALUE_WIDTH-1:0] params_d [NUMBER_PARAMS];

  logic                   sh_load, sh_up, sh_down;
  logic [VALUE_WIDTH-1:0] sh_load_value, shadow;
  logic [IW-1:0]          idx_next;

  assign idx_next = idx_q + IW'(1);

  sat_updown #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .VALUE_MIN   (VALUE_MIN),
    .VALUE_MAX   (VALUE_MAX)
  ) u_shadow (
    .clk_i        (clk_i),
    .nReset_i     (nReset_i),
    .load_i       (sh_load),
    .load_value_i (sh_load_value),
    .up_i         (sh_up),
    .down_i       (sh_down),
    .value_o      (shadow)
  );

  // Priority inside EDIT: commit, then mode, then plus/minus, then timeout.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    commit_d      = 1'b0;
    timeout_d     = 1'b0;
    params_d      = params_q;
    sh_load       = 1'b0;
    sh_load_value = '0;
    sh_up         = 1'b0;
    sh_down       = 1'b0;
    unique case (state_q)
      VIEW: begin
        cnt_d = '0;
        if (bus.mode_i) begin
          state_d       = EDIT;
          idx_d         = '0;
          sh_load       = 1'b1;
          sh_load_value = params_q[0];
        end
      end
      EDIT: begin
        if (bus.button_4_i) begin
          params_d[idx_q] = shadow;
          commit_d        = 1'b1;
          state_d         = VIEW;
          idx_d           = '0;
          cnt_d           = '0;
          sh_load         = 1'b1;
        end else if (bus.mode_i) begin
          cnt_d   = '0;
          sh_load = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = VIEW;
            idx_d   = '0;
          end else begin
            idx_d         = idx_next;
            sh_load_value = params_q[idx_next];
          end
        end else if (bus.plus_i || bus.minus_i) begin
          cnt_d   = '0;
          sh_up   = bus.plus_i;
          sh_down = bus.minus_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = VIEW;
          timeout_d = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
          sh_load   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = VIEW;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nReset_i) begin
      state_q   <= VIEW;
      idx_q     <= '0;
      cnt_q     <= '0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      for (int k = 0; k < NUMBER_PARAMS; k++) params_q[k] <= VALUE_WIDTH'(RESET_VALUE);
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      commit_q  <= commit_d;
      timeout_q <= timeout_d;
      params_q  <= params_d;
    end
  end

  for (genvar k = 0; k < NUMBER_PARAMS; k++) begin : g_pack
    assign bus.params_o[k*VALUE_WIDTH +: VALUE_WIDTH] = params_q[k];
  end

  assign bus.edit_active_o = (state_q == EDIT);
  assign bus.edit_index_o  = idx_q;
  assign bus.edit_value_o  = shadow;
  assign bus.commit_o      = commit_q;
  assign bus.timeout_o     = timeout_q;

endmodule
